// File: rtl/bomberman_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bomberman_pkg
// Purpose  : Shared map geometry, tile codes and map controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package bomberman_pkg;

    localparam int NUM_ROW    = 11;
    localparam int NUM_COL    = 19;
    localparam int DEPTH      = NUM_ROW * NUM_COL;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    typedef enum logic [1:0] {
        FREE = 2'b00,
        PERM = 2'b01,
        DEST = 2'b10,
        BOMB = 2'b11
    } tile_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/map_init_gen.sv
`default_nettype none
// ============================================================================
// Module   : map_init_gen
// Purpose  : Arena sweep counters and layout rule; optional LFSR fill under
//            MAP_RANDOM_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module map_init_gen
    import bomberman_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output tile_t                 init_data,
    output logic                  init_last
);

    localparam int ROW_W = $clog2(NUM_ROW);
    localparam int COL_W = $clog2(NUM_COL);

    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  w_col_last;
    logic                  w_perm;

    assign w_col_last = (col_q == COL_W'(NUM_COL - 1));
    assign init_last  = w_col_last && (row_q == ROW_W'(NUM_ROW - 1));
    assign init_addr  = addr_q;

    // The address counter runs alongside row/col so no row*NUM_COL product is needed.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clear) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (en) begin
            if (init_last) begin
                row_d  = '0;
                col_d  = '0;
                addr_d = '0;
            end else if (w_col_last) begin
                row_d  = row_q + ROW_W'(1);
                col_d  = '0;
                addr_d = addr_q + ADDR_WIDTH'(1);
            end else begin
                col_d  = col_q + COL_W'(1);
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign w_perm = (row_q == '0) || (row_q == ROW_W'(NUM_ROW - 1)) ||
                    (col_q == '0) || w_col_last ||
                    (!row_q[0] && !col_q[0]);

`ifdef MAP_RANDOM_FILL_EN
    logic [7:0] lfsr_q;
    logic       w_spawn;

    // Seeded on reset only so successive rounds produce different maps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign w_spawn = ((row_q == ROW_W'(1)) && (col_q == COL_W'(1))) ||
                     ((row_q == ROW_W'(1)) && (col_q == COL_W'(2))) ||
                     ((row_q == ROW_W'(2)) && (col_q == COL_W'(1)));

    always_comb begin
        init_data = FREE;
        if (w_perm) begin
            init_data = PERM;
        end else if (!w_spawn && (lfsr_q[1:0] != 2'b00)) begin
            init_data = DEST;
        end
    end
`else
    assign init_data = w_perm ? PERM : FREE;
`endif

endmodule
`default_nettype wire

// File: rtl/map_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : map_mem_ctrl
// Purpose  : 19x11 tile map with init sweep, registered read port and checked
//            valid/ready write port. Optional macro: MAP_RANDOM_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module map_mem_ctrl
    import bomberman_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]            rd_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [1:0]            wr_data,
    output logic                  wr_reject,
    output logic                  init_done
);

    state_t                state_q, state_d;
    tile_t                 rd_data_q, rd_data_d;
    logic                  wr_reject_q, wr_reject_d;
    tile_t                 mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_init_addr;
    tile_t                 w_init_data;
    logic                  w_init_last;
    logic                  w_init_en;
    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    tile_t                 w_wr_stored;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_commit;

    assign w_init_en = (state_q == ST_INIT);

    map_init_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_init_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_init_en),
        .clear     (restart),
        .init_addr (w_init_addr),
        .init_data (w_init_data),
        .init_last (w_init_last)
    );

    assign w_rd_in_range = (rd_addr < ADDR_WIDTH'(DEPTH));
    assign w_wr_in_range = (wr_addr < ADDR_WIDTH'(DEPTH));
    assign w_wr_stored   = w_wr_in_range ? mem[wr_addr] : PERM;
    assign w_accept      = wr_valid && (state_q == ST_RUN);
    assign w_drop        = !w_wr_in_range || (w_wr_stored == PERM) || (wr_data == PERM);
    // A restart in the same cycle discards the write silently.
    assign w_commit      = w_accept && !restart && !w_drop;

    always_comb begin
        state_d     = state_q;
        rd_data_d   = PERM;
        wr_reject_d = w_accept && !restart && w_drop;
        case (state_q)
            ST_INIT: if (!restart && w_init_last) state_d = ST_RUN;
            ST_RUN:  if (restart) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
        // Readers see walls throughout the rebuild, starting with the restart cycle.
        if (!w_init_en && !restart && w_rd_in_range) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            rd_data_q   <= PERM;
            wr_reject_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_init_en) begin
            mem[w_init_addr] <= w_init_data;
        end else if (w_commit) begin
            mem[wr_addr] <= tile_t'(wr_data);
        end
    end

    assign rd_data   = rd_data_q;
    assign wr_reject = wr_reject_q;
    assign wr_ready  = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);

endmodule
`default_nettype wire
